mdu_div_seq: RTL and testbench

- Multi-cycle 32-bit integer divider for the CPU execute stage, implementing DIV/DIVU.
- Sits directly downstream of the immediate/operand extension stage and consumes its 32-bit extended operands.
- Its `sign` input uses the same convention as the extender's `sext`: 1 means signed.
- Produces quotient (LO) and remainder (HI) using a start/busy/done handshake, so the pipeline controller can stall while the divide runs.

---
 rtl/mdu_div_seq_if.sv | 31 +++
 rtl/mdu_div_seq.sv | 141 ++++++++++++++
 tb/tb_mdu_div_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_div_seq_if.sv
// Operand/result bundle for the sequential divider.
// Latency: n/a (signal grouping only).
// Backpressure: none; the master watches busy/done before issuing start.
//
// Signals:
//   start, sign, dividend, divisor          : request side (master -> slave)
//   quotient, remainder, busy, done,
//   div_by_zero                             : result side (slave -> master)
interface mdu_div_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             sign;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   modport master (
      output start, sign, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, sign, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

// File: rtl/mdu_div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Latency: 33 cycles from accepted start to the one-cycle done pulse.
// Backpressure: none; start is ignored while busy, results hold until the next op.
//
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset, priority over start
//   div_if : slave side of mdu_div_seq_if (start/sign/dividend/divisor in,
//            quotient/remainder/busy/done/div_by_zero out)
module mdu_div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic          clk,
   input logic          rst,
   mdu_div_seq_if.slave div_if
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;       // partial remainder
   logic [WIDTH-1:0] r_q;         // dividend magnitude shifting out, quotient bits shifting in
   logic [WIDTH-1:0] r_dvs;       // divisor magnitude
   logic [WIDTH-1:0] r_raw;       // untouched dividend, returned as remainder on divide-by-zero
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dbz;

   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remd;
   logic             r_done;
   logic             r_dbz_out;

   logic             w_accept;
   logic             w_last;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_rem_nxt;

   assign w_accept = (r_state == S_IDLE) && div_if.start;
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   // Magnitudes: only signed ops with a set MSB get negated.
   assign w_a_neg = div_if.sign & div_if.dividend[WIDTH-1];
   assign w_b_neg = div_if.sign & div_if.divisor[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~div_if.dividend + 1'b1) : div_if.dividend;
   assign w_b_mag = w_b_neg ? (~div_if.divisor + 1'b1) : div_if.divisor;

   // One restoring step. The shifted remainder needs WIDTH+1 bits because an
   // unsigned divisor can be as large as 2^WIDTH-1. When the compare passes,
   // the true difference is below the divisor, so WIDTH bits of it suffice.
   assign w_shift   = {r_rem, r_q[WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, r_dvs});
   assign w_sub     = w_shift[WIDTH-1:0] - r_dvs;
   assign w_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (div_if.start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)       w_state_nxt = S_FIX;
         S_FIX:                     w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_q       <= '0;
         r_dvs     <= '0;
         r_raw     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dbz     <= 1'b0;
         r_quot    <= '0;
         r_remd    <= '0;
         r_done    <= 1'b0;
         r_dbz_out <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_raw   <= div_if.dividend;
            r_neg_q <= div_if.sign & (div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1]);
            r_neg_r <= div_if.sign & div_if.dividend[WIDTH-1];
            r_dbz   <= (div_if.divisor == '0);
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[WIDTH-2:0], w_ge};
         end else if (r_state == S_FIX) begin
            r_done    <= 1'b1;
            r_dbz_out <= r_dbz;
            if (r_dbz) begin
               // Divide-by-zero: all-ones quotient, raw dividend, no sign fix-up.
               r_quot <= '1;
               r_remd <= r_raw;
            end else begin
               r_quot <= r_neg_q ? (~r_q + 1'b1) : r_q;
               r_remd <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
            end
         end
      end
   end

   assign div_if.quotient    = r_quot;
   assign div_if.remainder   = r_remd;
   assign div_if.busy        = (r_state != S_IDLE);
   assign div_if.done        = r_done;
   assign div_if.div_by_zero = r_dbz_out;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Scoreboard bench for mdu_div_seq: expectations queued at start, checked on done.
module tb_mdu_div_seq;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_err;
   exp_t sb[$];

   mdu_div_seq_if #(.WIDTH(32)) bus ();

   mdu_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk    (clk),
      .rst    (rst),
      .div_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.dbz = 1'b0;
      e.cyc = 0;
      if (b == 32'd0) begin
         e.q   = 32'hFFFF_FFFF;
         e.r   = a;
         e.dbz = 1'b1;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
         end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
         end
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   // Drives a one-cycle start from the current time; the edge that follows is E0.
   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz);
      exp_t e;
      bus.start    = 1'b1;
      bus.sign     = s;
      bus.dividend = a;
      bus.divisor  = b;
      e.q   = eq;
      e.r   = er;
      e.dbz = edbz;
      e.cyc = cyc + 34;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.sign     = 1'($urandom_range(0, 1));
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
   endtask

   task automatic issue_model(input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e = model(s, a, b);
      issue(s, a, b, e.q, e.r, e.dbz);
   endtask

   // Returns at the negedge of the done cycle; counts busy cycles seen before it.
   task automatic wait_done(output int nbusy);
      bit found;
      found = 1'b0;
      nbusy = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done) begin
            found = 1'b1;
            break;
         end
         if (bus.busy) nbusy++;
      end
      if (!found) check("done_timeout", 32'd0, 32'd1);
   endtask

   // Result monitor.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", bus.quotient, e.q);
            check("remainder", bus.remainder, e.r);
            check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
            check("latency", 32'(cyc), 32'(e.cyc));
            check("busy_in_done", 32'(bus.busy), 32'd0);
         end
      end
   end

   initial begin
      int nb;
      int ndone;
      n_chk = 0;
      n_err = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.sign     = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_quotient", bus.quotient, 32'd0);
      check("rst_remainder", bus.remainder, 32'd0);
      check("rst_dbz", 32'(bus.div_by_zero), 32'd0);

      // Unsigned 100/7, busy for exactly 33 cycles.
      @(posedge clk); #1;
      issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      wait_done(nb);
      check("busy_cycles", 32'(nb), 32'd33);

      // Signed -7/2 and the same operands unsigned.
      @(posedge clk); #1;
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      wait_done(nb);
      @(posedge clk); #1;
      issue(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
      wait_done(nb);

      // Divide by zero, both signednesses; then signed overflow.
      @(posedge clk); #1;
      issue(1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      wait_done(nb);
      @(posedge clk); #1;
      issue(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      wait_done(nb);
      @(posedge clk); #1;
      issue(1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);
      wait_done(nb);
      @(posedge clk); #1;
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      wait_done(nb);
      check("dbz_cleared", 32'(bus.div_by_zero), 32'd0);

      // Start while busy is ignored.
      @(posedge clk); #1;
      issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.sign = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(nb);

      // Start in the done cycle: back-to-back accept.
      issue(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
      wait_done(nb);
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      wait_done(nb);

      // Random operands against the reference model.
      for (int i = 0; i < 6; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic        s;
         a = $urandom;
         b = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i == 3) b = -32'sd13;
         s = 1'(i % 2);
         @(posedge clk); #1;
         issue_model(s, a, b);
         wait_done(nb);
      end

      // Reset during an operation.
      @(posedge clk); #1;
      issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_quotient", bus.quotient, 32'd0);
      check("abort_remainder", bus.remainder, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);

      @(posedge clk); #1;
      issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
      wait_done(nb);

      // Reset wins over a simultaneous start.
      @(posedge clk); #1;
      rst = 1'b1;
      bus.start = 1'b1; bus.sign = 1'b0; bus.dividend = 32'd8; bus.divisor = 32'd2;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check("rst_over_start_busy", 32'(bus.busy), 32'd0);
      repeat (40) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
